// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl -- initiator side of the PCPI coprocessor interface.
//   Accepts an M-extension op on a valid/ready command port, builds the R-type
//   insn word, runs the PCPI handshake with one responder, and returns the result
//   on a valid/ready response port. Ops that no responder claims within
//   WAIT_TIMEOUT cycles, or that stay claimed without a result for MAX_LATENCY
//   cycles, finish with an error response so the PCPI bus never stays stuck.
// Latency: pcpi_valid rises the cycle after command accept; rsp_valid rises the
//   cycle after pcpi_ready (or the timeout) is sampled; all outputs registered.
// Backpressure: cmd_ready is low from accept until the response is taken;
//   rsp_* hold stable while rsp_valid & !rsp_ready.
// Ports:
//   clk, reset (sync, active-high)
//   cmd_valid/cmd_ready, cmd_funct3, cmd_rs1_idx, cmd_rs2_idx, cmd_rd_idx, cmd_rs1, cmd_rs2
//   pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2  (to responder)
//   pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready    (from responder)
//   rsp_valid/rsp_ready, rsp_data, rsp_wr, rsp_err, rsp_rd_idx, rsp_cycles
// Optional: define PCPI_ISSUE_PERF_EN to add perf_ops, perf_busy, perf_errs.

module pcpi_issue_ctrl #(
   parameter int WAIT_TIMEOUT = 16,
   parameter int MAX_LATENCY  = 1024,
   parameter int LAT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_funct3,
   input  logic [4:0]       cmd_rs1_idx,
   input  logic [4:0]       cmd_rs2_idx,
   input  logic [4:0]       cmd_rd_idx,
   input  logic [31:0]      cmd_rs1,
   input  logic [31:0]      cmd_rs2,
   output logic             pcpi_valid,
   output logic [31:0]      pcpi_insn,
   output logic [31:0]      pcpi_rs1,
   output logic [31:0]      pcpi_rs2,
   input  logic             pcpi_wr,
   input  logic [31:0]      pcpi_rd,
   input  logic             pcpi_wait,
   input  logic             pcpi_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_wr,
   output logic             rsp_err,
   output logic [4:0]       rsp_rd_idx,
   output logic [LAT_W-1:0] rsp_cycles
`ifdef PCPI_ISSUE_PERF_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_busy,
   output logic [15:0]      perf_errs
`endif
);

   localparam int TMR_MAX = (MAX_LATENCY > WAIT_TIMEOUT) ? MAX_LATENCY : WAIT_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] WAIT_T = TMR_W'(WAIT_TIMEOUT);
   localparam logic [TMR_W-1:0] MAX_T  = TMR_W'(MAX_LATENCY);
   localparam logic [31:0] LAT_SAT = (LAT_W >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << LAT_W) - 64'd1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic               claimed, claimed_nxt;
   logic               cmd_ready_nxt, pcpi_valid_nxt, rsp_valid_nxt;
   logic [31:0]        pcpi_insn_nxt, pcpi_rs1_nxt, pcpi_rs2_nxt, rsp_data_nxt;
   logic               rsp_wr_nxt, rsp_err_nxt;
   logic [4:0]         rsp_rd_idx_nxt;
   logic [LAT_W-1:0]   rsp_cycles_nxt;
   logic               seen;
   logic [31:0]        timer32;

   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer;
      claimed_nxt    = claimed;
      cmd_ready_nxt  = cmd_ready;
      pcpi_valid_nxt = pcpi_valid;
      pcpi_insn_nxt  = pcpi_insn;
      pcpi_rs1_nxt   = pcpi_rs1;
      pcpi_rs2_nxt   = pcpi_rs2;
      rsp_valid_nxt  = rsp_valid;
      rsp_data_nxt   = rsp_data;
      rsp_wr_nxt     = rsp_wr;
      rsp_err_nxt    = rsp_err;
      rsp_rd_idx_nxt = rsp_rd_idx;
      rsp_cycles_nxt = rsp_cycles;
      // a claim in the current cycle counts as seen for the unclaimed check
      seen           = claimed | pcpi_wait;
      timer32        = 32'(timer);

      case (state)
         IDLE: begin
            cmd_ready_nxt = 1'b1;
            if (cmd_valid && cmd_ready) begin
               pcpi_insn_nxt  = {7'b0000001, cmd_rs2_idx, cmd_rs1_idx, cmd_funct3,
                                 cmd_rd_idx, 7'b0110011};
               pcpi_rs1_nxt   = cmd_rs1;
               pcpi_rs2_nxt   = cmd_rs2;
               rsp_rd_idx_nxt = cmd_rd_idx;
               pcpi_valid_nxt = 1'b1;
               timer_nxt      = TMR_W'(1);
               claimed_nxt    = 1'b0;
               cmd_ready_nxt  = 1'b0;
               state_nxt      = ISSUE;
            end
         end
         ISSUE: begin
            cmd_ready_nxt = 1'b0;
            // pcpi_ready has priority over both timeouts in the same cycle
            if (pcpi_ready || (!seen && timer >= WAIT_T) || timer >= MAX_T) begin
               pcpi_valid_nxt = 1'b0;
               rsp_valid_nxt  = 1'b1;
               rsp_err_nxt    = !pcpi_ready;
               rsp_data_nxt   = pcpi_ready ? pcpi_rd : 32'd0;
               rsp_wr_nxt     = pcpi_ready & pcpi_wr;
               rsp_cycles_nxt = LAT_W'((timer32 > LAT_SAT) ? LAT_SAT : timer32);
               state_nxt      = RESP;
            end else begin
               timer_nxt   = timer + TMR_W'(1);
               claimed_nxt = seen;
            end
         end
         RESP: begin
            cmd_ready_nxt = 1'b0;
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt      = IDLE;
            pcpi_valid_nxt = 1'b0;
            rsp_valid_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         claimed    <= 1'b0;
         cmd_ready  <= 1'b0;
         pcpi_valid <= 1'b0;
         pcpi_insn  <= '0;
         pcpi_rs1   <= '0;
         pcpi_rs2   <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_wr     <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rd_idx <= '0;
         rsp_cycles <= '0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         claimed    <= claimed_nxt;
         cmd_ready  <= cmd_ready_nxt;
         pcpi_valid <= pcpi_valid_nxt;
         pcpi_insn  <= pcpi_insn_nxt;
         pcpi_rs1   <= pcpi_rs1_nxt;
         pcpi_rs2   <= pcpi_rs2_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_data   <= rsp_data_nxt;
         rsp_wr     <= rsp_wr_nxt;
         rsp_err    <= rsp_err_nxt;
         rsp_rd_idx <= rsp_rd_idx_nxt;
         rsp_cycles <= rsp_cycles_nxt;
      end
   end

`ifdef PCPI_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_ops  <= '0;
         perf_busy <= '0;
         perf_errs <= '0;
      end else begin
         if (state != IDLE)
            perf_busy <= perf_busy + 32'd1;
         if (state == RESP && rsp_ready) begin
            perf_ops <= perf_ops + 32'd1;
            if (rsp_err && perf_errs != 16'hFFFF)
               perf_errs <= perf_errs + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl: a behavioural multiplier responder, a table of
// directed ops, hand-written reset/stray-handshake sequences and randomized ops
// checked against an arithmetic reference model.

module tb_pcpi_issue_ctrl;
    localparam int WAIT_T = 16;
    localparam int MAX_T  = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_funct3;
    logic [4:0]  cmd_rs1_idx, cmd_rs2_idx, cmd_rd_idx;
    logic [31:0] cmd_rs1, cmd_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait, pcpi_ready;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_wr, rsp_err;
    logic [4:0]  rsp_rd_idx;
    logic [15:0] rsp_cycles;
`ifdef PCPI_ISSUE_PERF_EN
    logic [31:0] perf_ops, perf_busy;
    logic [15:0] perf_errs;
`endif

    always #5 clk = ~clk;

    pcpi_issue_ctrl #(.WAIT_TIMEOUT(WAIT_T), .MAX_LATENCY(MAX_T), .LAT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
        .cmd_rs1_idx(cmd_rs1_idx), .cmd_rs2_idx(cmd_rs2_idx), .cmd_rd_idx(cmd_rd_idx),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_wr(rsp_wr),
        .rsp_err(rsp_err), .rsp_rd_idx(rsp_rd_idx), .rsp_cycles(rsp_cycles)
`ifdef PCPI_ISSUE_PERF_EN
        , .perf_ops(perf_ops), .perf_busy(perf_busy), .perf_errs(perf_errs)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    function automatic void chk(input string name, input bit ok,
                                input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // M-extension multiply results from 64-bit products of extended operands
    function automatic logic [31:0] mext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f[1:0])
            2'd0:    p = sa * sb;
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // responder behaviour knobs
    int r_delay = 1;   // result on this cycle of pcpi_valid
    bit r_lazy  = 0;   // 1: never asserts pcpi_wait
    bit r_wr    = 1;
    bit stray   = 0;   // drive wait/ready while no request is pending

    // Behavioural responder: claims multiply insns only (funct3[2]==0).
    initial begin
        int  rcnt;
        bit  claim;
        rcnt = 0;
        pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_rd = '0; pcpi_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (pcpi_valid) begin
                rcnt++;
                claim = pcpi_insn[6:0] == 7'h33 && pcpi_insn[31:25] == 7'h01 && !pcpi_insn[14];
                pcpi_ready = claim && rcnt == r_delay;
                pcpi_wait  = claim && !r_lazy && rcnt < r_delay;
                pcpi_rd    = pcpi_ready ? mext(pcpi_insn[14:12], pcpi_rs1, pcpi_rs2) : 32'hDEAD_BEEF;
                pcpi_wr    = pcpi_ready ? r_wr : 1'b1;
            end else begin
                rcnt = 0;
                pcpi_ready = stray;
                pcpi_wait  = stray;
                pcpi_rd    = 32'h1234_5678;
                pcpi_wr    = stray;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: outcome of one op from the protocol rules.
    task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int dly, input bit lazy, input bit wr,
                         output logic [31:0] d, output bit err, output bit w, output int vcyc);
        bit claimed_op;
        claimed_op = !f3[2];
        err  = !claimed_op || (lazy && dly > WAIT_T) || (!lazy && dly > MAX_T);
        if (!err)                     vcyc = dly;
        else if (!claimed_op || lazy) vcyc = WAIT_T;
        else                          vcyc = MAX_T;
        d = err ? 32'd0 : mext(f3, a, b);
        w = err ? 1'b0 : wr;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int dly,
                          input bit lazy, input bit wr, input int hold,
                          input logic [31:0] ed, input bit ee, input bit ew, input int ev);
        logic [4:0]  s1, s2;
        logic [31:0] held;
        logic [31:0] exp_insn;
        int n, vcnt;
        s1 = 5'($urandom); s2 = 5'($urandom);
        r_delay = dly; r_lazy = lazy; r_wr = wr;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk({nm, " cmd_ready"}, cmd_ready === 1'b1, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_funct3 = f3; cmd_rs1 = a; cmd_rs2 = b;
        cmd_rs1_idx = s1; cmd_rs2_idx = s2; cmd_rd_idx = rd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_rs1 = $urandom; cmd_rs2 = $urandom; cmd_funct3 = 3'($urandom);
        @(negedge clk);
        exp_insn = {7'b0000001, s2, s1, f3, rd, 7'b0110011};
        chk({nm, " pcpi_valid_rise"}, pcpi_valid === 1'b1, pcpi_valid, 1);
        chk({nm, " insn"}, pcpi_insn === exp_insn, pcpi_insn, exp_insn);
        chk({nm, " pcpi_rs1"}, pcpi_rs1 === a, pcpi_rs1, a);
        chk({nm, " pcpi_rs2"}, pcpi_rs2 === b, pcpi_rs2, b);
        chk({nm, " cmd_ready_busy"}, cmd_ready === 1'b0, cmd_ready, 0);
        vcnt = 0; n = 0;
        while (!rsp_valid && n < MAX_T + 100) begin
            if (pcpi_valid) vcnt++;
            @(negedge clk); n++;
        end
        chk({nm, " rsp_valid_seen"}, rsp_valid === 1'b1, rsp_valid, 1);
        if (!rsp_valid) begin
            reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
            return;
        end
        chk({nm, " pcpi_valid_cycles"}, vcnt == ev, vcnt, ev);
        chk({nm, " pcpi_valid_low"}, pcpi_valid === 1'b0, pcpi_valid, 0);
        chk({nm, " rsp_data"}, rsp_data === ed, rsp_data, ed);
        chk({nm, " rsp_err"}, rsp_err === ee, rsp_err, ee);
        chk({nm, " rsp_wr"}, rsp_wr === ew, rsp_wr, ew);
        chk({nm, " rsp_rd_idx"}, rsp_rd_idx === rd, rsp_rd_idx, rd);
        if (!ee) chk({nm, " rsp_cycles"}, rsp_cycles === 16'(ev), rsp_cycles, ev);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, rsp_valid === 1'b1, rsp_valid, 1);
            chk({nm, " hold_data"}, rsp_data === held, rsp_data, held);
            chk({nm, " hold_cmd_ready"}, cmd_ready === 1'b0, cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, " rsp_valid_drop"}, rsp_valid === 1'b0, rsp_valid, 0);
        chk({nm, " cmd_ready_back"}, cmd_ready === 1'b1, cmd_ready, 1);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          dly;
        bit          lazy, wr;
        int          hold;
        logic [31:0] exp_data;
        bit          exp_err, exp_wr;
        int          exp_vcyc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, ed;
        bit          ee, ew, lz, wr;
        int          dly, ev;

        tbl[0]  = '{3'd0, 32'd3,          32'd7,          5'd5,  1,    1'b0, 1'b1, 0, 32'd21,         1'b0, 1'b1, 1};
        tbl[1]  = '{3'd1, 32'hFFFF_FFF6,  32'hFFFF_FFFC,  5'd6,  3,    1'b0, 1'b1, 1, 32'd0,          1'b0, 1'b1, 3};
        tbl[2]  = '{3'd2, 32'hFFFF_FFF6,  32'd4,          5'd7,  2,    1'b0, 1'b1, 0, 32'hFFFF_FFFF,  1'b0, 1'b1, 2};
        tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  4,    1'b0, 1'b1, 2, 32'hFFFF_FFFE,  1'b0, 1'b1, 4};
        tbl[4]  = '{3'd0, 32'd1000,       32'd1000,       5'd9,  2,    1'b0, 1'b1, 5, 32'd1000000,    1'b0, 1'b1, 2};
        tbl[5]  = '{3'd0, 32'd2,          32'd3,          5'd10, 16,   1'b1, 1'b1, 0, 32'd6,          1'b0, 1'b1, 16};
        tbl[6]  = '{3'd0, 32'd2,          32'd3,          5'd11, 17,   1'b1, 1'b1, 0, 32'd0,          1'b1, 1'b0, 16};
        tbl[7]  = '{3'd4, 32'd10,         32'd2,          5'd12, 1,    1'b0, 1'b1, 0, 32'd0,          1'b1, 1'b0, 16};
        tbl[8]  = '{3'd3, 32'd5,          32'd6,          5'd13, 1,    1'b0, 1'b0, 0, 32'd0,          1'b0, 1'b0, 1};
        tbl[9]  = '{3'd7, 32'd9,          32'd4,          5'd31, 1,    1'b0, 1'b1, 1, 32'd0,          1'b1, 1'b0, 16};
        tbl[10] = '{3'd0, 32'd12345,      32'd2,          5'd14, 20,   1'b0, 1'b1, 0, 32'd24690,      1'b0, 1'b1, 20};
        tbl[11] = '{3'd0, 32'd5,          32'd6,          5'd15, 2000, 1'b0, 1'b1, 0, 32'd0,          1'b1, 1'b0, MAX_T};

        cmd_valid = 1'b0; cmd_funct3 = '0; cmd_rs1_idx = '0; cmd_rs2_idx = '0; cmd_rd_idx = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; rsp_ready = 1'b0;

        // reset state, sampled while reset is still asserted
        repeat (2) @(negedge clk);
        chk("rst cmd_ready", cmd_ready === 1'b0, cmd_ready, 0);
        chk("rst pcpi_valid", pcpi_valid === 1'b0, pcpi_valid, 0);
        chk("rst rsp_valid", rsp_valid === 1'b0, rsp_valid, 0);
        chk("rst rsp_err", rsp_err === 1'b0, rsp_err, 0);
        chk("rst rsp_wr", rsp_wr === 1'b0, rsp_wr, 0);
        chk("rst pcpi_insn", pcpi_insn === 32'd0, pcpi_insn, 0);
        chk("rst pcpi_rs1", pcpi_rs1 === 32'd0, pcpi_rs1, 0);
        chk("rst rsp_data", rsp_data === 32'd0, rsp_data, 0);
        chk("rst rsp_cycles", rsp_cycles === 16'd0, rsp_cycles, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst cmd_ready", cmd_ready === 1'b1, cmd_ready, 1);

        // wait/ready while idle must be ignored
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray rsp_valid", rsp_valid === 1'b0, rsp_valid, 0);
            chk("stray pcpi_valid", pcpi_valid === 1'b0, pcpi_valid, 0);
        end
        stray = 1'b0;
        chk("stray cmd_ready", cmd_ready === 1'b1, cmd_ready, 1);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].dly,
                   tbl[i].lazy, tbl[i].wr, tbl[i].hold, tbl[i].exp_data, tbl[i].exp_err,
                   tbl[i].exp_wr, tbl[i].exp_vcyc);

        // reset in the middle of ISSUE drops the op
        r_delay = 100; r_lazy = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_funct3 = 3'd0; cmd_rs1 = 32'd4; cmd_rs2 = 32'd4; cmd_rd_idx = 5'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst pcpi_valid_before", pcpi_valid === 1'b1, pcpi_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst pcpi_valid", pcpi_valid === 1'b0, pcpi_valid, 0);
        chk("midrst rsp_valid", rsp_valid === 1'b0, rsp_valid, 0);
        chk("midrst cmd_ready", cmd_ready === 1'b0, cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst cmd_ready_after", cmd_ready === 1'b1, cmd_ready, 1);
        chk("midrst rsp_valid_after", rsp_valid === 1'b0, rsp_valid, 0);
        run_op("after_rst", tbl[0].f3, tbl[0].a, tbl[0].b, tbl[0].rd, tbl[0].dly, tbl[0].lazy,
               tbl[0].wr, tbl[0].hold, tbl[0].exp_data, tbl[0].exp_err, tbl[0].exp_wr,
               tbl[0].exp_vcyc);

        // randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            f3  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a   = $urandom; b = $urandom;
            dly = $urandom_range(1, 20);
            lz  = 1'($urandom);
            wr  = 1'($urandom);
            model(f3, a, b, dly, lz, wr, ed, ee, ew, ev);
            run_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom), dly, lz, wr,
                   $urandom_range(0, 3), ed, ee, ew, ev);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
